ps2_mod_decode: RTL and testbench
=================================

// Module: ps2_mod_decode
// PURPOSE
//  Decodes a PS/2 Set-2 scancode byte stream back into a USB HID modifier byte plus key events.
//  Tracks the E0 (extended), F0 (break) and E1 (Pause) prefixes and maintains the 8-bit modifier state.
//  Emits the 9-bit key code of every other key ({E0 flag, code}) on a valid/ready event port.
//  Sits between the PS/2 host byte receiver and the HID/keyboard register file; it is the inverse of the HID-modifier-to-PS/2 encoder.
// PARAMETERS
//  TIMEOUT_CYCLES  65536  Max clk cycles allowed between prefix bytes before the prefix is dropped; 0 disables the timeout.
//  PASS_MODS       0      1: modifier keys are also emitted on the key port; 0: modifier keys only update usb_mod.
// PORTS
//  clk          in   1   system clock, all logic rising-edge
//  reset_n      in   1   asynchronous active-low reset
//  byte_valid   in   1   scancode byte offered
//  byte_data    in   8   scancode byte
//  byte_ready   out  1   byte accepted when byte_valid & byte_ready
//  usb_mod      out  8   HID modifiers: [0]LCtrl [1]LShift [2]LAlt [3]LGUI [4]RCtrl [5]RShift [6]RAlt [7]RGUI
//  mod_changed  out  1   one-cycle pulse, usb_mod changed this cycle
//  key_valid    out  1   key event pending
//  key_code     out  9   {extended, code}; Pause = 9'h0E1
//  key_break    out  1   1 = release, 0 = press
//  key_ready    in   1   key event consumed when key_valid & key_ready
//  proto_err    out  1   one-cycle pulse on a prefix timeout or an illegal prefix sequence
// BEHAVIOUR
//  Reset (async assert, sync release): usb_mod=0, mod_changed=0, key_valid=0, key_code=0, key_break=0, proto_err=0, FSM=IDLE, counters=0.
//  byte_ready = ~key_valid. While an event is pending, no byte is accepted.
//  FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (E1 seen, skip counter).
//   IDLE:    E0->EXT; F0->BRK; E1->PAUSE with skip=6; FA,AA,EE,FE,00,FF are dropped; other code c -> final(ext=0, brk=0, c).
//   EXT:     F0->EXT_BRK; E0/E1 -> proto_err and IDLE; 12 or 59 (fake shift) are dropped -> IDLE; other c -> final(1,0,c).
//   BRK:     E0/E1/F0 -> proto_err and IDLE; other c -> final(0,1,c).
//   EXT_BRK: E0/E1/F0 -> proto_err and IDLE; 12/59 are dropped -> IDLE; other c -> final(1,1,c).
//   PAUSE:   each accepted byte decrements skip. When the byte arrives at skip==0, event {9'h0E1, brk=0} -> IDLE. Contents are not checked.
//  final(e,b,c): the modifier index is looked up from 9-bit {e,c}: 014->0, 012->1, 011->2, 11F->3, 114->4, 059->5, 111->6, 127->7.
//   Modifier: usb_mod[idx] <= ~b on the cycle after acceptance. mod_changed pulses in that same cycle only if the bit value changed.
//   An event ({e,c}, b) is raised on the cycle after acceptance for a non-modifier, or for a modifier when PASS_MODS=1. The FSM returns to IDLE.
//  key_valid stays high, with key_code and key_break stable, until key_ready. It drops the cycle after the handshake.
//  Timeout: the counter clears on every accepted byte and counts while the FSM is in EXT/BRK/EXT_BRK/PAUSE.
//   When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, proto_err pulses, and the partial sequence is discarded.
//  Repeated make of a held modifier: the bit stays 1, no mod_changed. A break of an unpressed modifier: no change, no error.
//  Reset asserted mid-sequence: the prefix is lost and usb_mod is cleared immediately (async).
// TESTING
//  Stream 14, 12 -> usb_mod 8'h01 then 8'h03; mod_changed pulses twice; no key_valid (PASS_MODS=0).
//  Stream E0 14, E0 F0 14 -> usb_mod 8'h10 then 8'h00; E0 12 (fake shift) -> no change.
//  Stream 1C, F0 1C with key_ready held low 5 cycles -> key_code 9'h01C brk=0 held stable; byte_ready=0 until the handshake; then brk=1.
//  Stream E1 14 77 E1 F0 14 F0 77 -> exactly one event 9'h0E1 brk=0; usb_mod unchanged at 8'h00.
//  TIMEOUT_CYCLES=16: E0 then a 20-cycle idle, then 1C -> proto_err at cycle 15 after E0; the event is 9'h01C (not extended).
//  Hold 14 (usb_mod 8'h01), pulse reset_n low mid E0 -> usb_mod 8'h00 asynchronously; the next 1C decodes as non-extended.

Source files
------------

// File: rtl/ps2_mod_decode_if.sv
// ps2_mod_decode_if: scancode byte stream in, modifier state and key events out
//  byte_valid/byte_data/byte_ready : PS/2 byte stream (valid/ready)
//  usb_mod/mod_changed             : HID modifier byte and change pulse
//  key_valid/key_code/key_break/key_ready : key event port (valid/ready)
//  proto_err                       : prefix timeout / illegal prefix pulse
interface ps2_mod_decode_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic [7:0] usb_mod;
  logic       mod_changed;
  logic       key_valid;
  logic [8:0] key_code;
  logic       key_break;
  logic       key_ready;
  logic       proto_err;
  modport slave (
    input  byte_valid, byte_data, key_ready,
    output byte_ready, usb_mod, mod_changed, key_valid, key_code, key_break, proto_err
  );
  modport master (
    output byte_valid, byte_data, key_ready,
    input  byte_ready, usb_mod, mod_changed, key_valid, key_code, key_break, proto_err
  );
endinterface

// File: rtl/ps2_mod_decode.sv
// ps2_mod_decode: PS/2 Set-2 scancode stream to HID modifier byte plus key events
//  clk     : rising-edge clock
//  reset_n : asynchronous active-low reset
//  bus     : ps2_mod_decode_if.slave (byte stream in, modifiers/events/errors out)
module ps2_mod_decode #(
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter bit          PASS_MODS      = 1'b0
) (
  input logic             clk,
  input logic             reset_n,
  ps2_mod_decode_if.slave bus
);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  mod_q, mod_d;
  logic        mchg_q, mchg_d;
  logic        kv_q, kv_d;
  logic [8:0]  code_q, code_d;
  logic        brk_q, brk_d;
  logic        err_q, err_d;
  logic        acc, fin, fe, fb, tmo, pre, fake, drop, is_mod;
  logic [7:0]  d;
  logic [8:0]  key;
  logic [2:0]  idx;
  assign acc  = bus.byte_valid & ~kv_q;
  assign d    = bus.byte_data;
  assign pre  = (d == 8'hE0) | (d == 8'hE1) | (d == 8'hF0);
  assign fake = (d == 8'h12) | (d == 8'h59);
  assign drop = (d == 8'hFA) | (d == 8'hAA) | (d == 8'hEE) | (d == 8'hFE) | (d == 8'h00) | (d == 8'hFF);
  // Timeout fires on the edge where the idle count would reach TIMEOUT_CYCLES-1.
  assign tmo  = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) && !acc &&
                ((cnt_q + 32'd1) >= (TIMEOUT_CYCLES - 32'd1));
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cnt_d   = (acc || state_q == IDLE) ? '0 : cnt_q + 32'd1;
    mod_d   = mod_q;
    mchg_d  = 1'b0;
    kv_d    = kv_q & ~bus.key_ready;
    code_d  = code_q;
    brk_d   = brk_q;
    err_d   = 1'b0;
    fin     = 1'b0;
    fe      = 1'b0;
    fb      = 1'b0;
    is_mod  = 1'b1;
    idx     = 3'd0;
    if (acc) begin
      case (state_q)
        IDLE: begin
          state_d = (d == 8'hE0) ? EXT : (d == 8'hF0) ? BRK : (d == 8'hE1) ? PAUSE : IDLE;
          skip_d  = (d == 8'hE1) ? 3'd6 : skip_q;
          fin     = !pre && !drop;
        end
        EXT: begin
          state_d = (d == 8'hF0) ? EXT_BRK : IDLE;
          err_d   = (d == 8'hE0) | (d == 8'hE1);
          fin     = !pre && !fake;
          fe      = 1'b1;
        end
        BRK: begin
          state_d = IDLE;
          err_d   = pre;
          fin     = !pre;
          fb      = 1'b1;
        end
        EXT_BRK: begin
          state_d = IDLE;
          err_d   = pre;
          fin     = !pre && !fake;
          fe      = 1'b1;
          fb      = 1'b1;
        end
        PAUSE: begin
          state_d = (skip_q == 3'd0) ? IDLE : PAUSE;
          skip_d  = skip_q - 3'd1;
          kv_d    = (skip_q == 3'd0);
          code_d  = (skip_q == 3'd0) ? 9'h0E1 : code_q;
          brk_d   = (skip_q == 3'd0) ? 1'b0 : brk_q;
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo) begin
      state_d = IDLE;
      err_d   = 1'b1;
      cnt_d   = '0;
    end
    key = {fe, d};
    case (key)
      9'h014:  idx = 3'd0;
      9'h012:  idx = 3'd1;
      9'h011:  idx = 3'd2;
      9'h11F:  idx = 3'd3;
      9'h114:  idx = 3'd4;
      9'h059:  idx = 3'd5;
      9'h111:  idx = 3'd6;
      9'h127:  idx = 3'd7;
      default: is_mod = 1'b0;
    endcase
    if (fin) begin
      mod_d[idx] = is_mod ? ~fb : mod_q[idx];
      mchg_d     = is_mod && (mod_q[idx] == fb);
      kv_d       = !is_mod || PASS_MODS;
      code_d     = kv_d ? key : code_q;
      brk_d      = kv_d ? fb : brk_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      skip_q  <= '0;
      cnt_q   <= '0;
      mod_q   <= '0;
      mchg_q  <= 1'b0;
      kv_q    <= 1'b0;
      code_q  <= '0;
      brk_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      mchg_q  <= mchg_d;
      kv_q    <= kv_d;
      code_q  <= code_d;
      brk_q   <= brk_d;
      err_q   <= err_d;
    end
  end
  assign bus.byte_ready  = ~kv_q;
  assign bus.usb_mod     = mod_q;
  assign bus.mod_changed = mchg_q;
  assign bus.key_valid   = kv_q;
  assign bus.key_code    = code_q;
  assign bus.key_break   = brk_q;
  assign bus.proto_err   = err_q;
endmodule

// File: tb/tb_ps2_mod_decode.sv
// tb_ps2_mod_decode: directed bench for ps2_mod_decode
module tb_ps2_mod_decode;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  int mc_cnt = 0;
  int pe_cnt = 0;
  logic [8:0] ev_code = '0;
  logic ev_brk = 1'b0;
  int e0, m0, p0;
  logic [7:0] pause_seq [8];
  ps2_mod_decode_if ifc();
  ps2_mod_decode #(.TIMEOUT_CYCLES(16), .PASS_MODS(1'b0)) u_dut (
    .clk(clk), .reset_n(rst_n), .bus(ifc.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ifc.key_valid && ifc.key_ready) begin
      ev_cnt  <= ev_cnt + 1;
      ev_code <= ifc.key_code;
      ev_brk  <= ifc.key_break;
    end
    if (ifc.mod_changed) mc_cnt <= mc_cnt + 1;
    if (ifc.proto_err) pe_cnt <= pe_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    logic acc;
    @(negedge clk);
    ifc.byte_valid = 1'b1;
    ifc.byte_data  = b;
    do begin
      acc = ifc.byte_ready;
      @(posedge clk);
      n++;
    end while (!acc && n < 40);
    #1 ifc.byte_valid = 1'b0;
    check("byte_accept", acc, 1);
  endtask
  task automatic settle();
    @(posedge clk);
    #1;
  endtask
  initial begin
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    ifc.byte_valid = 1'b0;
    ifc.byte_data  = 8'h00;
    ifc.key_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mod", ifc.usb_mod, 8'h00);
    check("rst_kv", ifc.key_valid, 0);
    check("rst_code", ifc.key_code, 9'h000);
    check("rst_err", ifc.proto_err, 0);
    rst_n = 1'b1;
    settle();
    check("rst_rdy", ifc.byte_ready, 1);
    e0 = ev_cnt; m0 = mc_cnt;
    send(8'h14);
    check("lctrl_mod", ifc.usb_mod, 8'h01);
    check("lctrl_mc", ifc.mod_changed, 1);
    send(8'h12);
    check("lshift_mod", ifc.usb_mod, 8'h03);
    check("lshift_mc", ifc.mod_changed, 1);
    settle();
    check("mc_count", mc_cnt - m0, 2);
    check("mod_no_event", ev_cnt - e0, 0);
    send(8'h14);
    check("rep_mod", ifc.usb_mod, 8'h03);
    check("rep_mc", ifc.mod_changed, 0);
    send(8'hF0); send(8'h14);
    check("brk_lctrl", ifc.usb_mod, 8'h02);
    send(8'hF0); send(8'h12);
    check("brk_lshift", ifc.usb_mod, 8'h00);
    p0 = pe_cnt;
    send(8'hF0); send(8'h12);
    check("brk_unpressed_mod", ifc.usb_mod, 8'h00);
    check("brk_unpressed_mc", ifc.mod_changed, 0);
    settle();
    check("brk_unpressed_err", pe_cnt - p0, 0);
    send(8'hE0); send(8'h14);
    check("rctrl_mod", ifc.usb_mod, 8'h10);
    send(8'hE0); send(8'hF0); send(8'h14);
    check("rctrl_brk", ifc.usb_mod, 8'h00);
    check("rctrl_brk_mc", ifc.mod_changed, 1);
    e0 = ev_cnt;
    send(8'hE0); send(8'h12);
    check("fake_mod", ifc.usb_mod, 8'h00);
    check("fake_mc", ifc.mod_changed, 0);
    send(8'hFA); send(8'hAA);
    settle();
    check("fake_drop_event", ev_cnt - e0, 0);
    ifc.key_ready = 1'b0;
    send(8'h1C);
    check("hold_kv", ifc.key_valid, 1);
    check("hold_code", ifc.key_code, 9'h01C);
    check("hold_brk", ifc.key_break, 0);
    repeat (5) begin
      @(negedge clk);
      check("hold_kv_stable", ifc.key_valid, 1);
      check("hold_code_stable", ifc.key_code, 9'h01C);
      check("hold_rdy_low", ifc.byte_ready, 0);
    end
    e0 = ev_cnt;
    ifc.key_ready = 1'b1;
    settle();
    check("hs_kv_drop", ifc.key_valid, 0);
    check("hs_rdy", ifc.byte_ready, 1);
    check("hs_count", ev_cnt - e0, 1);
    check("hs_code", ev_code, 9'h01C);
    send(8'hF0); send(8'h1C);
    settle();
    check("a_brk_code", ev_code, 9'h01C);
    check("a_brk_brk", ev_brk, 1);
    send(8'hE0); send(8'h75);
    settle();
    check("ext_code", ev_code, 9'h175);
    check("ext_brk", ev_brk, 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    settle();
    check("extbrk_code", ev_code, 9'h175);
    check("extbrk_brk", ev_brk, 1);
    e0 = ev_cnt; m0 = mc_cnt;
    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    settle();
    check("pause_count", ev_cnt - e0, 1);
    check("pause_code", ev_code, 9'h0E1);
    check("pause_brk", ev_brk, 0);
    check("pause_mod", ifc.usb_mod, 8'h00);
    check("pause_mc", mc_cnt - m0, 0);
    p0 = pe_cnt;
    send(8'hE0);
    repeat (14) @(posedge clk);
    #1 check("tmo_early", ifc.proto_err, 0);
    settle();
    check("tmo_pulse", ifc.proto_err, 1);
    settle();
    check("tmo_pulse_end", ifc.proto_err, 0);
    repeat (4) @(posedge clk);
    send(8'h1C);
    settle();
    check("tmo_code", ev_code, 9'h01C);
    check("tmo_brk", ev_brk, 0);
    check("tmo_err_count", pe_cnt - p0, 1);
    p0 = pe_cnt;
    send(8'hE0); send(8'hE0);
    settle();
    check("ill_err", pe_cnt - p0, 1);
    send(8'h1C);
    settle();
    check("ill_recover", ev_code, 9'h01C);
    send(8'h14);
    check("rstmid_hold", ifc.usb_mod, 8'h01);
    send(8'hE0);
    #2 rst_n = 1'b0;
    #1 check("rstmid_async", ifc.usb_mod, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h1C);
    settle();
    check("rstmid_code", ev_code, 9'h01C);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
